// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive framing path.
//   state_t           - receive FSM states (PARITY exists only in parity builds' flow)
//   BIT_PERIOD        - sysclk cycles per bit at 9600 baud from 50 MHz
//   HALF_PERIOD       - cycles from start edge to first mid-bit sample
//   DEFAULT_DATA_BITS - default frame payload width
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  localparam int BIT_PERIOD        = 5208;
  localparam int HALF_PERIOD       = 2604;
  localparam int DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop synchroniser for an asynchronous single-bit input.
//   clk - sampling clock
//   rst - asynchronous active-high reset; every stage resets to 1 (idle line)
//   d   - asynchronous input
//   q   - synchronised output, DEPTH cycles behind d
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '1;
    else     ff <= {ff[DEPTH-2:0], d};
  end

  assign q = ff[DEPTH-1];

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: receive-side UART framing controller.
//   sysclk       - clock, rising edge
//   reset        - asynchronous active-high reset
//   rxd          - raw serial input, idle high
//   sample_pulse - mid-bit strobe from the timing block
//   sample_en    - keeps the timing block running (low clears its counter)
//   data         - last good byte, held until the next good frame
//   data_valid   - one-cycle strobe, data updated
//   frame_err    - one-cycle strobe, stop bit sampled low
//   parity_err   - one-cycle strobe, parity mismatch (0 without parity)
// Build option: define UART_RX_PARITY_EN to add a parity bit between the
// data bits and the stop bit; PARITY_ODD selects odd (1) or even (0) sense.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD  = 0
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 rxd,
  input  logic                 sample_pulse,
  output logic                 sample_en,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  state_t               state, state_nx;
  logic                 rxs, rxs_prev;
  logic [DATA_BITS-1:0] shreg;
  logic [CW-1:0]        cnt;
  logic                 perr;
  logic                 start_ok, shift_en, stop_hit;

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync (
    .clk (sysclk),
    .rst (reset),
    .d   (rxd),
    .q   (rxs)
  );

  assign start_ok = (state == ST_START) && sample_pulse && !rxs;
  assign shift_en = (state == ST_DATA)  && sample_pulse;
  assign stop_hit = (state == ST_STOP)  && sample_pulse;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (rxs_prev && !rxs) state_nx = ST_START;
      // A high start-bit sample is a glitch: drop back silently.
      ST_START:  if (sample_pulse) state_nx = rxs ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (sample_pulse && cnt == CW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
          state_nx = ST_PARITY;
`else
          state_nx = ST_STOP;
`endif
        end
      ST_PARITY: if (sample_pulse) state_nx = ST_STOP;
      // Leaving STOP mid-bit lets a start edge right after the stop bit be seen.
      ST_STOP:   if (sample_pulse) state_nx = rxs ? ST_IDLE : ST_BREAK;
      ST_BREAK:  if (rxs) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rxs_prev   <= 1'b1;
      sample_en  <= 1'b0;
      shreg      <= '0;
      cnt        <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rxs_prev   <= rxs;
      // Registered from next state so it rises with START and falls with IDLE/BREAK.
      sample_en  <= (state_nx == ST_START) || (state_nx == ST_DATA) ||
                    (state_nx == ST_PARITY) || (state_nx == ST_STOP);
      data_valid <= stop_hit && rxs && !perr;
      frame_err  <= stop_hit && !rxs;
      if (stop_hit && rxs && !perr) data <= shreg;
      if (start_ok)      cnt <= '0;
      else if (shift_en) cnt <= cnt + 1'b1;
      if (shift_en) shreg <= {rxs, shreg[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      perr       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= stop_hit && rxs && perr;
      if (start_ok) perr <= 1'b0;
      else if (state == ST_PARITY && sample_pulse)
        perr <= (rxs != ((^shreg) ^ (PARITY_ODD != 0)));
    end
  end
`else
  assign perr       = 1'b0;
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Receive-side framing controller for the 9600-baud serial link on `sysclk` (50 MHz). It synchronises the raw `rxd` line and detects the start-bit falling edge. It drives `sample_en` to the mid-bit timing block, then uses each returned `sample_pulse` to capture the start, data, optional parity and stop bits. Each completed frame is delivered as a parallel byte with a one-cycle valid strobe, or flagged as an error.

## Interface
- `DATA_BITS`, 8, data bits per frame, LSB first.
- `SYNC_STAGES`, 2, flip-flops in the `rxd` synchroniser (≥2).
- `PARITY_ODD`, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

- `sysclk` in 1: the single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `rxd` in 1: raw serial input, asynchronous, idle high.
- `sample_pulse` in 1: one-cycle mid-bit strobe from the timing block.
- `sample_en` out 1: registered; holds the timing block running; low resets its counter.
- `data` out DATA_BITS: last good byte; holds until the next good frame.
- `data_valid` out 1: one-cycle strobe, `data` updated this cycle.
- `frame_err` out 1: one-cycle strobe, stop bit sampled low.
- `parity_err` out 1: one-cycle strobe, parity mismatch.

## Operation
- `rxd` passes through SYNC_STAGES flops, all reset to 1.
  - One further flop holds the previous synced value for edge detection.
  - All decisions use the synced value `rxs`.
- **IDLE:** `sample_en`=0. A falling edge on `rxs` (prev 1, now 1→0) sets `sample_en`=1 and moves to START.
- **START:** on `sample_pulse`:
  - If `rxs`=0, clear the bit counter and go to DATA.
  - Otherwise it is a glitch: `sample_en`=0, return to IDLE, no error strobe.
- **DATA:** on each `sample_pulse`:
  - Shift right: `shreg <= {rxs, shreg[DATA_BITS-1:1]}`.
  - Increment the bit counter, width $clog2(DATA_BITS).
  - After the DATA_BITS-th pulse, go to PARITY (if compiled in), else STOP.
- **PARITY:** on `sample_pulse`:
  - Compute expected = ^shreg ^ PARITY_ODD.
  - Latch mismatch = (`rxs` != expected) and go to STOP.
- **STOP:** on `sample_pulse`, `sample_en`=0, then:
  - `rxs`=1, no parity mismatch: `data`<=`shreg`, `data_valid`=1, go to IDLE.
  - `rxs`=1, parity mismatch: `parity_err`=1, `data` unchanged, go to IDLE.
  - `rxs`=0: `frame_err`=1, `data` unchanged, go to BREAK.
- **BREAK:** wait for `rxs`=1, then go to IDLE. A new start is only accepted after the line returns high.
- `sample_pulse` is ignored in IDLE and BREAK.
- Strobes are mutually exclusive and never high on consecutive cycles.

## Timing
- Reset values: state IDLE, `sample_en` 0, `data` 0, `data_valid` 0, `frame_err` 0, `parity_err` 0, `shreg` 0, counter 0.
- **Edge detection:**
  - `rxd` falls to `sample_en` high: SYNC_STAGES+1 cycles.
  - The timing block then returns its first pulse about half a bit later (~2605 cycles), then one pulse every 5208 cycles.
- **Output latency:** `data_valid`, `frame_err` and `parity_err` rise on the cycle after the stop-bit `sample_pulse`. `sample_en` falls on that same edge.
- **Re-arm:** IDLE is re-entered mid-stop-bit, so a start edge arriving right after the stop bit is caught. The minimum idle between frames is 0 extra bits.
- **Reset mid-frame:** immediate return to IDLE. No strobe is emitted, `data` is cleared, and the partial frame is discarded.
- **sample_pulse on the same cycle as a START/IDLE transition:** only the current state's rule applies.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: the PARITY state exists and frames are start + DATA_BITS + parity + stop.
  - Undefined: the PARITY state and parity logic are removed, frames are start + DATA_BITS + stop, and `parity_err` is tied to 0. PARITY_ODD is then unused.

## Structure
- Shared package `uart_pkg`:
  - State enum for IDLE/START/DATA/PARITY/STOP/BREAK.
  - `BIT_PERIOD`=5208 and `HALF_PERIOD`=2604 constants, used by the bench and the timing block.
  - Default DATA_BITS.
- Sub-module `sync_ff` (parameterised depth, reset value 1) for the `rxd` synchroniser. The FSM and shift register live in the top module.

## Test plan
- **Good frame:** send 0xA5 8N1 at 5208 cycles/bit → one `data_valid`, `data`=0xA5, `sample_en` low afterwards, no errors.
- **Glitch:** `rxd` low for 100 cycles → `sample_en` high then low after the first pulse, no strobes, `data` unchanged.
- **Bad stop bit:** send 0x3C with stop bit 0, hold line low for 3 bits → `frame_err` pulse, `data` unchanged. A new frame 0x11 is accepted only after the line returns high.
- **Back-to-back frames:** 0x00, 0xFF, 0x55 with no idle gap → three `data_valid` strobes with matching values.
- **Reset mid-frame:** assert `reset` during data bit 4 → all outputs 0 immediately. The next full frame 0x81 is received correctly.
- **Parity (`UART_RX_PARITY_EN` defined, even):** 0x07 with parity 1 → `data_valid`. 0x07 with parity 0 → `parity_err`, `data` unchanged.
